// File: rtl/hazard_unit_if.sv
// hazard_unit_if: bundle between the pipeline datapath and the hazard unit.
//   Pipeline -> hazard unit: staged register specifiers, staged control bits
//     (regwrite/memtoreg/memwrite/branch/bne) and the data-memory ready.
//   Hazard unit -> pipeline: data-memory request, per-stage stall/flush,
//     forwarding selects, sticky memory-timeout flag and stall-cycle counter.
//   master: pipeline side.  slave: hazard unit side.
interface hazard_unit_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       rsD, rtD, rsE, rtE;
    logic [4:0]       writeregE, writeregM, writeregW;
    logic             regwriteE, regwriteM, regwriteW;
    logic             memtoregE, memtoregM, memwriteM;
    logic             branchD, bneD;
    logic             dmem_ready;

    logic             dmem_req;
    logic             stallF, stallD, stallE, stallM;
    logic             flushE, flushW;
    logic             forwardAD, forwardBD;
    logic [1:0]       forwardAE, forwardBE;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, memwriteM,
               branchD, bneD, dmem_ready,
        input  dmem_req, stallF, stallD, stallE, stallM, flushE, flushW,
               forwardAD, forwardBD, forwardAE, forwardBE, mem_err, stall_cycles
    );

    modport slave (
        input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, memwriteM,
               branchD, bneD, dmem_ready,
        output dmem_req, stallF, stallD, stallE, stallM, flushE, flushW,
               forwardAD, forwardBD, forwardAE, forwardBE, mem_err, stall_cycles
    );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush/forwarding control for a 5-stage pipeline, plus a
// data-memory wait FSM (req/ready) with timeout and a stall-cycle counter.
//   i_clk   : pipeline clock
//   i_rst_n : asynchronous active-low reset
//   io_hz   : hazard_unit_if.slave (staged specifiers/controls in, controls out)
// All control outputs are combinational; only FSM state, wait counter, error
// flag and stall counter are registered.
module hazard_unit #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input logic          i_clk,
    input logic          i_rst_n,
    hazard_unit_if.slave io_hz
);
    localparam int unsigned WCNT_W = $clog2(TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    typedef enum logic {StIdle, StWait} state_e;

    state_e            r_state, w_state_d;
    logic [WCNT_W-1:0] r_wait_cnt, w_wait_cnt_d;
    logic              r_mem_err, w_mem_err_d;
    logic [CNT_W-1:0]  r_stall_cycles;

    logic       w_lwstall, w_branchstall, w_memwait, w_dmem_req, w_stall_fd;
    logic [1:0] w_fwd_ae, w_fwd_be;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (reg_match(src, io_hz.writeregM) && io_hz.regwriteM) return 2'b10;
        if (reg_match(src, io_hz.writeregW) && io_hz.regwriteW) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        w_fwd_ae = fwd_sel(io_hz.rsE);
        w_fwd_be = fwd_sel(io_hz.rtE);
        w_lwstall = io_hz.memtoregE &&
                    (reg_match(io_hz.rsD, io_hz.writeregE) ||
                     reg_match(io_hz.rtD, io_hz.writeregE));
        w_branchstall = (io_hz.branchD || io_hz.bneD) &&
                        ((io_hz.regwriteE &&
                          (reg_match(io_hz.rsD, io_hz.writeregE) ||
                           reg_match(io_hz.rtD, io_hz.writeregE))) ||
                         (io_hz.memtoregM &&
                          (reg_match(io_hz.rsD, io_hz.writeregM) ||
                           reg_match(io_hz.rtD, io_hz.writeregM))));
        w_dmem_req = (io_hz.memtoregM || io_hz.memwriteM) && !r_mem_err;
    end

    // Wait FSM: memwait is high in every cycle the access has not completed,
    // so the ready cycle itself advances and stall length equals wait cycles.
    always_comb begin
        w_state_d    = r_state;
        w_wait_cnt_d = r_wait_cnt;
        w_mem_err_d  = r_mem_err;
        w_memwait    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_dmem_req && !io_hz.dmem_ready) begin
                    w_memwait    = 1'b1;
                    w_state_d    = StWait;
                    w_wait_cnt_d = '0;
                end
            end
            StWait: begin
                if (io_hz.dmem_ready) begin
                    w_state_d = StIdle;
                end else begin
                    w_memwait = !r_mem_err;
                    if (r_wait_cnt == WCNT_LAST) begin
                        // Abandon the access; error stays set until reset.
                        w_state_d   = StIdle;
                        w_mem_err_d = 1'b1;
                    end else begin
                        w_wait_cnt_d = r_wait_cnt + 1'b1;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= StIdle;
            r_wait_cnt     <= '0;
            r_mem_err      <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state    <= w_state_d;
            r_wait_cnt <= w_wait_cnt_d;
            r_mem_err  <= w_mem_err_d;
            if (w_stall_fd && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
        end
    end

    assign w_stall_fd = w_lwstall || w_branchstall || w_memwait;

    assign io_hz.dmem_req     = w_dmem_req;
    assign io_hz.stallF       = w_stall_fd;
    assign io_hz.stallD       = w_stall_fd;
    assign io_hz.stallE       = w_memwait;
    assign io_hz.stallM       = w_memwait;
    assign io_hz.flushW       = w_memwait;
    // While memory holds, E is frozen rather than bubbled.
    assign io_hz.flushE       = (w_lwstall || w_branchstall) && !w_memwait;
    assign io_hz.forwardAD    = reg_match(io_hz.rsD, io_hz.writeregM) && io_hz.regwriteM;
    assign io_hz.forwardBD    = reg_match(io_hz.rtD, io_hz.writeregM) && io_hz.regwriteM;
    assign io_hz.forwardAE    = w_fwd_ae;
    assign io_hz.forwardBE    = w_fwd_be;
    assign io_hz.mem_err      = r_mem_err;
    assign io_hz.stall_cycles = r_stall_cycles;
endmodule
